// File: rtl/dm_pkg.sv
// ============================================================================
// Module   : dm (package)
// Purpose  : Debug Module Interface types and DTM status codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

endpackage : dm

`default_nettype wire

// File: rtl/dmi_initiator.sv
// ============================================================================
// Module   : dmi_initiator
// Purpose  : Turns host commands into DMI transactions, with sticky error
//            status, request timeout and hard-reset abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_initiator
    import dm::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  dtm_op_e     cmd_op_i,
    input  logic [6:0]  cmd_addr_i,
    input  logic [31:0] cmd_data_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_status_o,

    output logic [1:0]  dmistat_o,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,

    output logic        dmi_rst_no,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output dmi_req_t    dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  dmi_resp_t   dmi_resp_i
);

    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    state_e          state_q,      state_d;
    logic [CntW-1:0] cnt_q,        cnt_d;
    logic [1:0]      stat_q,       stat_d;
    logic [31:0]     rsp_data_q,   rsp_data_d;
    logic [1:0]      rsp_status_q, rsp_status_d;
    logic            rsp_valid_q,  rsp_valid_d;
    logic            req_valid_q,  req_valid_d;
    dmi_req_t        req_q,        req_d;
    logic            dmi_rst_n_q,  dmi_rst_n_d;

    logic [CntW:0]   cnt_next;
    logic            timeout;
    logic            set_en;
    logic [1:0]      set_val;

    // One extra bit so the compare cannot wrap when TimeoutCycles is 2^n-1.
    assign cnt_next = {1'b0, cnt_q} + (CntW+1)'(1);
    assign timeout  = (TimeoutCycles != 0) && (cnt_next >= (CntW+1)'(TimeoutCycles));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_valid_d  = rsp_valid_q;
        req_valid_d  = req_valid_q;
        req_d        = req_q;
        dmi_rst_n_d  = 1'b1;
        set_en       = 1'b0;
        set_val      = DTM_SUCCESS;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    if (stat_q != DTM_SUCCESS) begin
                        state_d      = S_RSP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = stat_q;
                        rsp_data_d   = '0;
                    end else if (cmd_op_i == DTM_READ || cmd_op_i == DTM_WRITE) begin
                        req_d       = '{addr: cmd_addr_i, op: cmd_op_i, data: cmd_data_i};
                        req_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_REQ;
                    end else begin
                        state_d      = S_RSP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = DTM_SUCCESS;
                        rsp_data_d   = '0;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = timeout ? cnt_q : cnt_next[CntW-1:0];
                if (state_q == S_REQ && dmi_req_ready_i) begin
                    req_valid_d = 1'b0;
                    state_d     = S_WAIT;
                end else if (state_q == S_WAIT && dmi_resp_valid_i) begin
                    rsp_data_d   = dmi_resp_i.data;
                    rsp_status_d = dmi_resp_i.resp;
                    rsp_valid_d  = 1'b1;
                    set_en       = (dmi_resp_i.resp != DTM_SUCCESS);
                    set_val      = dmi_resp_i.resp;
                    state_d      = S_RSP;
                end else if (timeout) begin
                    req_valid_d  = 1'b0;
                    dmi_rst_n_d  = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = DTM_BUSY;
                    rsp_data_d   = '0;
                    set_en       = 1'b1;
                    set_val      = DTM_BUSY;
                    state_d      = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh error recorded this cycle outranks a host clear.
        stat_d = stat_q;
        if (dmireset_i) begin
            stat_d = DTM_SUCCESS;
        end
        if (set_en && stat_q == DTM_SUCCESS) begin
            stat_d = set_val;
        end

        if (dmihardreset_i) begin
            state_d     = S_IDLE;
            stat_d      = DTM_SUCCESS;
            rsp_valid_d = 1'b0;
            req_valid_d = 1'b0;
            dmi_rst_n_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stat_q       <= DTM_SUCCESS;
            rsp_data_q   <= '0;
            rsp_status_q <= DTM_SUCCESS;
            rsp_valid_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            req_q        <= '0;
            dmi_rst_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stat_q       <= stat_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_valid_q  <= rsp_valid_d;
            req_valid_q  <= req_valid_d;
            req_q        <= req_d;
            dmi_rst_n_q  <= dmi_rst_n_d;
        end
    end

    assign cmd_ready_o      = (state_q == S_IDLE);
    assign dmi_resp_ready_o = (state_q == S_WAIT);
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_status_o     = rsp_status_q;
    assign dmistat_o        = stat_q;
    assign dmi_rst_no       = dmi_rst_n_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_o        = req_q;

endmodule : dmi_initiator

`default_nettype wire

// File: tb/tb_dmi_initiator.sv
// ============================================================================
// Module   : tb_dmi_initiator
// Purpose  : Directed self-checking bench for dmi_initiator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmi_initiator;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    dm::dtm_op_e    cmd_op_i;
    logic [6:0]     cmd_addr_i;
    logic [31:0]    cmd_data_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [31:0]    rsp_data_o;
    logic [1:0]     rsp_status_o;
    logic [1:0]     dmistat_o;
    logic           dmireset_i;
    logic           dmihardreset_i;
    logic           dmi_rst_no;
    logic           dmi_req_valid_o;
    logic           dmi_req_ready_i;
    dm::dmi_req_t   dmi_req_o;
    logic           dmi_resp_valid_i;
    logic           dmi_resp_ready_o;
    dm::dmi_resp_t  dmi_resp_i;

    int vecs = 0;
    int errs = 0;
    int dmi_req_cnt = 0;

    always #5 clk_i = ~clk_i;

    dmi_initiator #(.TimeoutCycles(8)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_op_i         (cmd_op_i),
        .cmd_addr_i       (cmd_addr_i),
        .cmd_data_i       (cmd_data_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_data_o       (rsp_data_o),
        .rsp_status_o     (rsp_status_o),
        .dmistat_o        (dmistat_o),
        .dmireset_i       (dmireset_i),
        .dmihardreset_i   (dmihardreset_i),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_o        (dmi_req_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_i       (dmi_resp_i)
    );

    always @(posedge clk_i) begin
        if (rst_ni && dmi_req_valid_o && dmi_req_ready_i) dmi_req_cnt++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_cmd(input dm::dtm_op_e op, input logic [6:0] addr, input logic [31:0] data);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
    endtask

    task automatic idle_inputs();
        cmd_valid_i      = 1'b0;
        cmd_op_i         = dm::DTM_NOP;
        cmd_addr_i       = '0;
        cmd_data_i       = '0;
        rsp_ready_i      = 1'b0;
        dmireset_i       = 1'b0;
        dmihardreset_i   = 1'b0;
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_i       = '0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        vecs++; if (cmd_ready_o !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); end
        vecs++; if (rsp_valid_o !== 1'b0 || dmi_req_valid_o !== 1'b0) begin errs++; $display("FAIL reset_valids: got rsp %b req %b want 0 0", rsp_valid_o, dmi_req_valid_o); end
        vecs++; if (dmi_req_o !== '0 || rsp_data_o !== 32'h0 || rsp_status_o !== 2'd0) begin errs++; $display("FAIL reset_data: got req %h data %h st %h want 0", dmi_req_o, rsp_data_o, rsp_status_o); end
        vecs++; if (dmistat_o !== 2'd0 || dmi_rst_no !== 1'b1) begin errs++; $display("FAIL reset_stat: got stat %h rst_n %b want 0 1", dmistat_o, dmi_rst_no); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_write();
        dm::dmi_req_t exp;
        int n0;
        exp = '{addr: 7'h10, op: dm::DTM_WRITE, data: 32'h1};
        dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1; dmi_resp_i = '0; rsp_ready_i = 1'b1;
        n0 = dmi_req_cnt;
        drive_cmd(dm::DTM_WRITE, 7'h10, 32'h1);
        vecs++; if (cmd_ready_o !== 1'b1) begin errs++; $display("FAIL write_cmd_ready: got %b want 1", cmd_ready_o); end
        tick();
        cmd_valid_i = 1'b0;
        vecs++; if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== exp) begin errs++; $display("FAIL write_req: got v %b %h want 1 %h", dmi_req_valid_o, dmi_req_o, exp); end
        vecs++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b0) begin errs++; $display("FAIL write_early1: got rsp %b rdy %b want 0 0", rsp_valid_o, cmd_ready_o); end
        tick();
        vecs++; if (rsp_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1) begin errs++; $display("FAIL write_wait: got rsp %b respready %b want 0 1", rsp_valid_o, dmi_resp_ready_o); end
        tick();
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd0) begin errs++; $display("FAIL write_rsp: got v %b st %h want 1 0", rsp_valid_o, rsp_status_o); end
        vecs++; if (dmi_req_cnt - n0 !== 1) begin errs++; $display("FAIL write_req_count: got %0d want 1", dmi_req_cnt - n0); end
        tick();
        vecs++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin errs++; $display("FAIL write_done: got rsp %b rdy %b want 0 1", rsp_valid_o, cmd_ready_o); end
        idle_inputs();
    endtask

    task automatic test_read_stall();
        dm::dmi_req_t exp;
        exp = '{addr: 7'h11, op: dm::DTM_READ, data: 32'h12345678};
        drive_cmd(dm::DTM_READ, 7'h11, 32'h12345678);
        tick();
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vecs++; if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== exp) begin errs++; $display("FAIL stall_payload[%0d]: got v %b %h want 1 %h", i, dmi_req_valid_o, dmi_req_o, exp); end
            tick();
        end
        dmi_req_ready_i = 1'b1;
        vecs++; if (dmi_req_valid_o !== 1'b1 || dmi_req_o !== exp) begin errs++; $display("FAIL stall_handshake: got v %b %h want 1 %h", dmi_req_valid_o, dmi_req_o, exp); end
        tick();
        dmi_req_ready_i = 1'b0;
        vecs++; if (dmi_req_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b1) begin errs++; $display("FAIL stall_wait: got req %b respready %b want 0 1", dmi_req_valid_o, dmi_resp_ready_o); end
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i = '{data: 32'hDEADBEEF, resp: 2'd0};
        tick();
        dmi_resp_valid_i = 1'b0;
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hDEADBEEF || rsp_status_o !== 2'd0) begin errs++; $display("FAIL read_rsp: got v %b %h st %h want 1 deadbeef 0", rsp_valid_o, rsp_data_o, rsp_status_o); end
        tick();
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hDEADBEEF) begin errs++; $display("FAIL read_rsp_hold: got v %b %h want 1 deadbeef", rsp_valid_o, rsp_data_o); end
        rsp_ready_i = 1'b1;
        tick();
        vecs++; if (rsp_valid_o !== 1'b0) begin errs++; $display("FAIL read_rsp_drop: got %b want 0", rsp_valid_o); end
        idle_inputs();
    endtask

    task automatic test_error_sticky();
        int n0;
        dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1; rsp_ready_i = 1'b1;
        dmi_resp_i = '{data: 32'hCAFE0000, resp: 2'd2};
        drive_cmd(dm::DTM_READ, 7'h12, 32'h0);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd2 || rsp_data_o !== 32'hCAFE0000) begin errs++; $display("FAIL err_rsp: got v %b st %h %h want 1 2 cafe0000", rsp_valid_o, rsp_status_o, rsp_data_o); end
        vecs++; if (dmistat_o !== 2'd2) begin errs++; $display("FAIL err_dmistat: got %h want 2", dmistat_o); end
        tick();
        n0 = dmi_req_cnt;
        drive_cmd(dm::DTM_READ, 7'h12, 32'h0);
        tick();
        cmd_valid_i = 1'b0;
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd2 || rsp_data_o !== 32'h0 || dmi_req_valid_o !== 1'b0) begin errs++; $display("FAIL err_drop: got v %b st %h %h req %b want 1 2 0 0", rsp_valid_o, rsp_status_o, rsp_data_o, dmi_req_valid_o); end
        tick();
        vecs++; if (dmi_req_cnt !== n0 || dmistat_o !== 2'd2) begin errs++; $display("FAIL err_no_traffic: got cnt %0d stat %h want %0d 2", dmi_req_cnt, dmistat_o, n0); end
        dmireset_i = 1'b1;
        tick();
        dmireset_i = 1'b0;
        vecs++; if (dmistat_o !== 2'd0) begin errs++; $display("FAIL dmireset_clear: got %h want 0", dmistat_o); end
        dmi_resp_i = '{data: 32'h00000055, resp: 2'd0};
        drive_cmd(dm::DTM_READ, 7'h13, 32'h0);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd0 || rsp_data_o !== 32'h55 || dmi_req_cnt !== n0 + 1) begin errs++; $display("FAIL err_recover: got v %b st %h %h cnt %0d want 1 0 55 %0d", rsp_valid_o, rsp_status_o, rsp_data_o, dmi_req_cnt, n0 + 1); end
        tick();
        idle_inputs();
    endtask

    task automatic test_nop();
        int n0;
        n0 = dmi_req_cnt;
        drive_cmd(dm::DTM_NOP, 7'h20, 32'hFFFFFFFF);
        tick();
        cmd_valid_i = 1'b0;
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd0 || rsp_data_o !== 32'h0 || dmi_req_valid_o !== 1'b0) begin errs++; $display("FAIL nop_rsp: got v %b st %h %h req %b want 1 0 0 0", rsp_valid_o, rsp_status_o, rsp_data_o, dmi_req_valid_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        vecs++; if (dmi_req_cnt !== n0 || cmd_ready_o !== 1'b1) begin errs++; $display("FAIL nop_idle: got cnt %0d rdy %b want %0d 1", dmi_req_cnt, cmd_ready_o, n0); end
    endtask

    task automatic test_timeout();
        drive_cmd(dm::DTM_WRITE, 7'h14, 32'h7);
        dmi_req_ready_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        dmi_req_ready_i = 1'b0;
        for (int i = 2; i < 8; i++) begin
            tick();
            vecs++; if (rsp_valid_o !== 1'b0 || dmi_rst_no !== 1'b1) begin errs++; $display("FAIL timeout_early[%0d]: got rsp %b rst_n %b want 0 1", i, rsp_valid_o, dmi_rst_no); end
        end
        tick();
        vecs++; if (rsp_valid_o !== 1'b1 || rsp_status_o !== 2'd3 || rsp_data_o !== 32'h0) begin errs++; $display("FAIL timeout_rsp: got v %b st %h %h want 1 3 0", rsp_valid_o, rsp_status_o, rsp_data_o); end
        vecs++; if (dmistat_o !== 2'd3 || dmi_rst_no !== 1'b0 || dmi_req_valid_o !== 1'b0) begin errs++; $display("FAIL timeout_abort: got stat %h rst_n %b req %b want 3 0 0", dmistat_o, dmi_rst_no, dmi_req_valid_o); end
        tick();
        vecs++; if (dmi_rst_no !== 1'b1 || rsp_valid_o !== 1'b1) begin errs++; $display("FAIL timeout_pulse: got rst_n %b rsp %b want 1 1", dmi_rst_no, rsp_valid_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        dmihardreset_i = 1'b1;
        tick();
        dmihardreset_i = 1'b0;
        vecs++; if (dmistat_o !== 2'd0 || dmi_rst_no !== 1'b0) begin errs++; $display("FAIL hardreset_idle: got stat %h rst_n %b want 0 0", dmistat_o, dmi_rst_no); end
        tick();
    endtask

    task automatic test_hardreset_wait();
        drive_cmd(dm::DTM_READ, 7'h15, 32'h0);
        dmi_req_ready_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        dmi_req_ready_i = 1'b0;
        vecs++; if (dmi_resp_ready_o !== 1'b1) begin errs++; $display("FAIL hard_in_wait: got %b want 1", dmi_resp_ready_o); end
        dmihardreset_i = 1'b1;
        dmi_resp_valid_i = 1'b1;
        dmi_resp_i = '{data: 32'h11111111, resp: 2'd2};
        tick();
        dmihardreset_i = 1'b0;
        dmi_resp_valid_i = 1'b0;
        vecs++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b0) begin errs++; $display("FAIL hard_idle: got rdy %b rsp %b respready %b want 1 0 0", cmd_ready_o, rsp_valid_o, dmi_resp_ready_o); end
        vecs++; if (dmistat_o !== 2'd0 || dmi_rst_no !== 1'b0) begin errs++; $display("FAIL hard_stat: got stat %h rst_n %b want 0 0", dmistat_o, dmi_rst_no); end
        tick();
        vecs++; if (dmi_rst_no !== 1'b1 || rsp_valid_o !== 1'b0) begin errs++; $display("FAIL hard_after: got rst_n %b rsp %b want 1 0", dmi_rst_no, rsp_valid_o); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_req();
        dmi_req_ready_i = 1'b1; dmi_resp_valid_i = 1'b1;
        dmi_resp_i = '{data: 32'hA5A5A5A5, resp: 2'd0};
        drive_cmd(dm::DTM_READ, 7'h16, 32'h0);
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        vecs++; if (rsp_data_o !== 32'hA5A5A5A5) begin errs++; $display("FAIL pre_reset_data: got %h want a5a5a5a5", rsp_data_o); end
        dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        drive_cmd(dm::DTM_WRITE, 7'h17, 32'h99);
        tick();
        cmd_valid_i = 1'b0;
        vecs++; if (dmi_req_valid_o !== 1'b1) begin errs++; $display("FAIL mid_req_valid: got %b want 1", dmi_req_valid_o); end
        rst_ni = 1'b0;
        tick();
        vecs++; if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || dmi_req_valid_o !== 1'b0) begin errs++; $display("FAIL rst_mid_ctrl: got rdy %b rsp %b req %b want 1 0 0", cmd_ready_o, rsp_valid_o, dmi_req_valid_o); end
        vecs++; if (dmi_req_o !== '0 || rsp_data_o !== 32'h0 || rsp_status_o !== 2'd0) begin errs++; $display("FAIL rst_mid_data: got req %h data %h st %h want 0 0 0", dmi_req_o, rsp_data_o, rsp_status_o); end
        vecs++; if (dmistat_o !== 2'd0 || dmi_rst_no !== 1'b1) begin errs++; $display("FAIL rst_mid_stat: got stat %h rst_n %b want 0 1", dmistat_o, dmi_rst_no); end
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_write();
        test_read_stall();
        test_error_sticky();
        test_nop();
        test_timeout();
        test_hardreset_wait();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule : tb_dmi_initiator

`default_nettype wire

// File: doc/dmi_initiator.md
DMI_INITIATOR -- requirements
Module: dmi_initiator

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 1024, giving the maximum cycles in REQ+WAIT before abort; 0 disables the timeout.
REQ-002 SHALL have one clock; reset is synchronous and active-low: clk_i input 1 (rising-edge clock), rst_ni input 1 (synchronous active-low reset).
REQ-003 SHALL have cmd_valid_i input 1, host command valid.
REQ-004 SHALL have cmd_ready_o output 1, command accepted when high with cmd_valid_i.
REQ-005 SHALL have cmd_op_i input dm::dtm_op_e (2), NOP/READ/WRITE.
REQ-006 SHALL have cmd_addr_i input 7, DM register address.
REQ-007 SHALL have cmd_data_i input 32, write data.
REQ-008 SHALL have rsp_valid_o output 1, host response valid.
REQ-009 SHALL have rsp_ready_i input 1, host response ready.
REQ-010 SHALL have rsp_data_o output 32, read data.
REQ-011 SHALL have rsp_status_o output 2, 0 = success, 2 = failed, 3 = busy.
REQ-012 SHALL have dmistat_o output 2, sticky error status.
REQ-013 SHALL have dmireset_i input 1, clears dmistat.
REQ-014 SHALL have dmihardreset_i input 1, aborts everything.
REQ-015 SHALL have dmi_rst_no output 1, active-low DMI reset to the DM.
REQ-016 SHALL have dmi_req_valid_o output 1, dmi_req_ready_i input 1, and dmi_req_o output dm::dmi_req_t.
REQ-017 SHALL have dmi_resp_valid_i input 1, dmi_resp_ready_o output 1, and dmi_resp_i input dm::dmi_resp_t.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, RSP; cmd_ready_o = 1 only in IDLE.
REQ-019 SHALL, in IDLE on an accepted command with dmistat_o != 0, drop it (no DMI traffic) and enter RSP with rsp_status_o = dmistat_o and rsp_data_o = 0.
REQ-020 SHALL, in IDLE on an accepted NOP with dmistat_o == 0, enter RSP with status 0 and data 0, without DMI traffic.
REQ-021 SHALL, in IDLE on an accepted READ/WRITE with dmistat_o == 0, register addr/op/data into dmi_req_o and enter REQ the next cycle.
REQ-022 SHALL, in REQ, hold dmi_req_valid_o = 1 with a stable payload until dmi_req_ready_i, then go to WAIT; it SHALL never deassert valid before the handshake except on abort.
REQ-023 SHALL drive dmi_resp_ready_o = 1 only in WAIT.
REQ-024 SHALL, in WAIT on dmi_resp_valid_i, capture data and resp into rsp_data_o/rsp_status_o, and set dmistat_o = resp if dmistat_o == 0 and resp != 0, then go to RSP.
REQ-025 SHALL, in RSP, hold rsp_valid_o with stable data until rsp_ready_i, then return to IDLE; minimum command-to-response latency is 3 cycles for READ/WRITE with immediate DMI handshakes.
REQ-026 SHALL count cycles in REQ and WAIT with a $clog2(TimeoutCycles+1)-bit counter cleared on entry to REQ; on reaching TimeoutCycles it SHALL pulse dmi_rst_no low for 1 cycle, set dmistat_o = 3 (if 0), and enter RSP with status 3 and data 0.
REQ-027 SHALL, on dmireset_i, clear dmistat_o the next cycle; when a same-cycle set occurs (REQ-024/026), the set wins.
REQ-028 SHALL, on dmihardreset_i in any state, go to IDLE, clear dmistat_o, drop any pending host response, deassert all valids, and drive dmi_rst_no low for exactly the next cycle.
REQ-029 SHALL give dmihardreset_i priority over every other event in the same cycle.

Reset
REQ-030 SHALL, while rst_ni = 0 at a clock edge, set FSM = IDLE, dmistat_o = 0, rsp_data_o = 0, rsp_status_o = 0, rsp_valid_o = 0, dmi_req_valid_o = 0, dmi_req_o = 0, counter = 0, dmi_rst_no = 1.
REQ-031 SHALL have all outputs registered except cmd_ready_o and dmi_resp_ready_o, which decode the FSM state.

Structure
REQ-032 SHALL take dtm_op_e, dmi_req_t, dmi_resp_t, and the status codes (DTM_SUCCESS = 0, DTM_ERR = 2, DTM_BUSY = 3) from package dm; the FSM state enum SHALL be local.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 SHALL verify: WRITE addr 0x10 data 0x1 with ready/valid tied high -> one dmi_req {0x10, WRITE, 0x1}, rsp status 0 three cycles after accept.
REQ-035 SHALL verify: READ addr 0x11 with dmi_req_ready_i stalled 5 cycles and resp data 0xDEADBEEF -> payload stable throughout, rsp_data_o = 0xDEADBEEF.
REQ-036 SHALL verify: DM returns resp = 2 -> dmistat_o = 2; next READ produces no DMI traffic and status 2; after a dmireset_i pulse, a READ proceeds normally.
REQ-037 SHALL verify: TimeoutCycles = 8 with the DM never responding -> dmi_rst_no low 1 cycle, rsp status 3, dmistat_o = 3.
REQ-038 SHALL verify: dmihardreset_i asserted in WAIT -> IDLE next cycle, no rsp_valid_o, dmistat_o = 0, dmi_rst_no low 1 cycle.
REQ-039 SHALL verify: rst_ni low mid-REQ -> all outputs at REQ-030 values the next cycle.
